// File: rtl/musa_pkg.sv
// rtl/musa_pkg.sv - shared MUSA core types and defaults
package musa_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_NOR = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - ID/EX pipeline register bundle
interface id_ex_register_if
  import musa_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
);
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     ReadData1;
  logic [DATA_WIDTH-1:0]     ReadData2;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_alu_src;
  logic                      id_reg_dst;
  logic [3:0]                id_alu_op;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_write_register;
  logic [DATA_WIDTH-1:0]     wb_write_data;
  logic                      flush;
  logic                      ex_hold;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_pc;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [DATA_WIDTH-1:0]     ex_op_a;
  logic [DATA_WIDTH-1:0]     ex_op_b;
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [REG_ADDR_WIDTH-1:0] ex_dest;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_alu_src;
  logic [3:0]                ex_alu_op;
  logic                      id_stall;
  logic [31:0]               bubble_count;

  modport master (
    output id_valid, id_pc, id_imm, id_rs, id_rt, id_rd, ReadData1, ReadData2,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_alu_op,
           wb_reg_write, wb_write_register, wb_write_data, flush, ex_hold,
    input  ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b, ex_rs, ex_rt, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op,
           id_stall, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs, id_rt, id_rd, ReadData1, ReadData2,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_alu_op,
           wb_reg_write, wb_write_register, wb_write_data, flush, ex_hold,
    output ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b, ex_rs, ex_rt, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op,
           id_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_register_load_use_detect.sv
// rtl/id_ex_register_load_use_detect.sv - load-use hazard detector
module load_use_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  output logic                      load_use
);
  // A load in EX whose result ID needs cannot be bypassed in time; register 0 never counts
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == id_rs) || (ex_dest == id_rt));
endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with WB bypass and load-use bubble
module id_ex_register
  import musa_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  id_ex_register_if.slave bus
);
  logic                      ex_valid_q;
  logic [DATA_WIDTH-1:0]     pc_q, imm_q, op_a_q, op_b_q;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q, dest_q;
  id_ex_ctrl_t               ctrl_q;
  id_ex_ctrl_t               id_ctrl;
  logic [31:0]               bubble_q;
  logic                      load_use;
  logic                      insert_clear;

  // Register 0 reads as zero; a same-cycle WB write to the source wins over stale RF data
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic                      wb_en,
    input logic [REG_ADDR_WIDTH-1:0] wb_idx,
    input logic [DATA_WIDTH-1:0]     wb_data,
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]     rf_data
  );
    if (idx == '0) return '0;
    if (wb_en && (wb_idx == idx)) return wb_data;
    return rf_data;
  endfunction

  load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_load_use_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_dest     (dest_q),
    .id_valid    (bus.id_valid),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .load_use    (load_use)
  );

  assign id_ctrl = '{reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                     mem_write: bus.id_mem_write, alu_src: bus.id_alu_src,
                     alu_op: bus.id_alu_op};

  // Flush beats hold; a hazard only bubbles once EX is free to accept it
  assign insert_clear = bus.flush || (!bus.ex_hold && load_use);
  assign bus.id_stall = (bus.ex_hold || load_use) && !bus.flush;

  // Pipeline state: clear on flush/bubble, freeze on hold, otherwise capture ID
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      ctrl_q     <= '0;
      bubble_q   <= '0;
    end else if (insert_clear) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      ctrl_q     <= '0;
      if (!bus.flush && (bubble_q != 32'hFFFF_FFFF)) bubble_q <= bubble_q + 32'd1;
    end else if (!bus.ex_hold) begin
      ex_valid_q <= bus.id_valid;
      pc_q       <= bus.id_pc;
      imm_q      <= bus.id_imm;
      op_a_q     <= select_operand(bus.wb_reg_write, bus.wb_write_register,
                                   bus.wb_write_data, bus.id_rs, bus.ReadData1);
      op_b_q     <= select_operand(bus.wb_reg_write, bus.wb_write_register,
                                   bus.wb_write_data, bus.id_rt, bus.ReadData2);
      rs_q       <= bus.id_rs;
      rt_q       <= bus.id_rt;
      dest_q     <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      ctrl_q     <= id_ctrl;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_op_a      = op_a_q;
  assign bus.ex_op_b      = op_b_q;
  assign bus.ex_rs        = rs_q;
  assign bus.ex_rt        = rt_q;
  assign bus.ex_dest      = dest_q;
  assign bus.ex_reg_write = ctrl_q.reg_write;
  assign bus.ex_mem_read  = ctrl_q.mem_read;
  assign bus.ex_mem_write = ctrl_q.mem_write;
  assign bus.ex_alu_src   = ctrl_q.alu_src;
  assign bus.ex_alu_op    = ctrl_q.alu_op;
  assign bus.bubble_count = bubble_q;
endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - scoreboard bench for id_ex_register
module tb_id_ex_register;
  import musa_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, op_a, op_b;
    logic [4:0]  rs, rt, dest;
    logic        reg_write, mem_read, mem_write, alu_src;
    logic [3:0]  alu_op;
    logic [31:0] bcount;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  ex_t  m;
  ex_t  sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] pc_cnt = 32'h100;

  always #5 clk = ~clk;

  id_ex_register_if bus();

  id_ex_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare_ex(input ex_t e);
    check_eq("ex_valid", bus.ex_valid, e.valid);
    check_eq("ex_pc", bus.ex_pc, e.pc);
    check_eq("ex_imm", bus.ex_imm, e.imm);
    check_eq("ex_op_a", bus.ex_op_a, e.op_a);
    check_eq("ex_op_b", bus.ex_op_b, e.op_b);
    check_eq("ex_rs_rt_dest", {bus.ex_rs, bus.ex_rt, bus.ex_dest}, {e.rs, e.rt, e.dest});
    check_eq("ex_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src,
                         bus.ex_alu_op},
             {e.reg_write, e.mem_read, e.mem_write, e.alu_src, e.alu_op});
    check_eq("bubble_count", bus.bubble_count, e.bcount);
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_reg_write && bus.wb_write_register == idx) return bus.wb_write_data;
    return rf;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic rdst, input logic rw, input logic mr, input logic mw,
                        input logic [3:0] op);
    pc_cnt           = pc_cnt + 32'd4;
    bus.id_valid     = v;
    bus.id_pc        = pc_cnt;
    bus.id_imm       = $urandom;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.ReadData1    = rd1;
    bus.ReadData2    = rd2;
    bus.id_reg_dst   = rdst;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_alu_src   = 1'($urandom_range(0, 1));
    bus.id_alu_op    = op;
  endtask

  // Called just after a falling edge: predict, check stall, push, then compare after the rising edge
  task automatic step();
    ex_t  n;
    ex_t  got;
    logic lu;
    #1;
    lu = bus.id_valid && m.valid && m.mem_read && (m.dest != 5'd0) &&
         ((m.dest == bus.id_rs) || (m.dest == bus.id_rt));
    check_eq("id_stall", bus.id_stall, (bus.ex_hold || lu) && !bus.flush);
    n = m;
    if (bus.flush) begin
      n = '0;
      n.bcount = m.bcount;
    end else if (bus.ex_hold) begin
      n = m;
    end else if (lu) begin
      n = '0;
      n.bcount = (m.bcount == 32'hFFFF_FFFF) ? m.bcount : m.bcount + 32'd1;
    end else begin
      n.valid     = bus.id_valid;
      n.pc        = bus.id_pc;
      n.imm       = bus.id_imm;
      n.op_a      = operand(bus.id_rs, bus.ReadData1);
      n.op_b      = operand(bus.id_rt, bus.ReadData2);
      n.rs        = bus.id_rs;
      n.rt        = bus.id_rt;
      n.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      n.reg_write = bus.id_reg_write;
      n.mem_read  = bus.id_mem_read;
      n.mem_write = bus.id_mem_write;
      n.alu_src   = bus.id_alu_src;
      n.alu_op    = bus.id_alu_op;
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      compare_ex(got);
      m = got;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    m = '0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
    bus.wb_reg_write = 1'b0;
    bus.wb_write_register = 5'd0;
    bus.wb_write_data = 32'd0;
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    #2;
    compare_ex('0);
    check_eq("reset_id_stall", bus.id_stall, 1'b0);
    #10 reset = 1'b1;
    @(negedge clk);

    // Normal flow
    set_id(1'b1, 5'd3, 5'd4, 5'd7, 32'h1234, 32'h5678, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD);
    step();
    check_eq("normal_op_a", bus.ex_op_a, 32'h1234);
    check_eq("normal_op_b", bus.ex_op_b, 32'h5678);
    check_eq("normal_dest", bus.ex_dest, 5'd7);
    check_eq("normal_valid", bus.ex_valid, 1'b1);

    // WB bypass, both operands, then register 0 never bypassed
    bus.wb_reg_write = 1'b1;
    bus.wb_write_register = 5'd3;
    bus.wb_write_data = 32'hDEAD;
    set_id(1'b1, 5'd3, 5'd3, 5'd9, 32'h1111, 32'h2222, 1'b0, 1'b1, 1'b0, 1'b0, ALU_SUB);
    step();
    check_eq("bypass_op_a", bus.ex_op_a, 32'hDEAD);
    check_eq("bypass_op_b", bus.ex_op_b, 32'hDEAD);
    bus.wb_write_register = 5'd0;
    set_id(1'b1, 5'd0, 5'd2, 5'd9, 32'h3333, 32'h4444, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OR);
    step();
    check_eq("r0_op_a", bus.ex_op_a, 32'd0);
    bus.wb_reg_write = 1'b0;

    // Load-use: lw to r5, then add reading r5
    set_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
    step();
    set_id(1'b1, 5'd5, 5'd2, 5'd6, 32'hAA, 32'hBB, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD);
    step();
    check_eq("lu_bubble_valid", bus.ex_valid, 1'b0);
    check_eq("lu_bubble_count", bus.bubble_count, 32'd1);
    step();
    check_eq("lu_add_enters", bus.ex_valid, 1'b1);

    // Reset pulse mid-cycle with ex_hold high
    set_id(1'b1, 5'd4, 5'd8, 5'd0, 32'h55, 32'h66, 1'b0, 1'b1, 1'b1, 1'b0, ALU_AND);
    step();
    bus.ex_hold = 1'b1;
    #1 reset = 1'b0;
    #2;
    compare_ex('0);
    check_eq("reset_stall_follows_hold", bus.id_stall, 1'b1);
    #1 reset = 1'b1;
    bus.ex_hold = 1'b0;
    m = '0;
    @(negedge clk);

    // Hold for 4 cycles with a hazard pending, then flush on top of both
    set_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h77, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
    step();
    bus.ex_hold = 1'b1;
    set_id(1'b1, 5'd5, 5'd2, 5'd6, 32'h88, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, ALU_XOR);
    for (int i = 0; i < 4; i++) step();
    check_eq("hold_frozen_mem_read", bus.ex_mem_read, 1'b1);
    bus.flush = 1'b1;
    step();
    check_eq("flush_valid", bus.ex_valid, 1'b0);
    check_eq("flush_count_unchanged", bus.bubble_count, 32'd0);
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;

    // Saturation of the bubble counter
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
    m.bcount = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      set_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
      step();
      set_id(1'b1, 5'd2, 5'd5, 5'd6, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD);
      step();
      step();
    end
    check_eq("saturated_count", bus.bubble_count, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between the decode (ID) and execute (EX) stages of the MUSA core. It captures decoded control, immediate and register-file operands each cycle. It bypasses same-cycle write-back data around the register file and detects load-use hazards, inserting one bubble and stalling upstream. It also honours EX back-pressure and branch flush, and counts bubble cycles for performance monitoring.

## Interface
- DATA_WIDTH, 32, operand/PC/immediate width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_pc, id_imm  in  DATA_WIDTH  PC and sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH  source/destination indices
- ReadData1, ReadData2  in  DATA_WIDTH  register-file data for id_rs/id_rt, aligned with id_valid
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  in  1 each  decoded control
- id_alu_op  in  4  ALU operation code
- wb_reg_write  in  1  write-back enable
- wb_write_register  in  REG_ADDR_WIDTH  write-back index
- wb_write_data  in  DATA_WIDTH  write-back data
- flush  in  1  branch/jump redirect from EX
- ex_hold  in  1  EX busy; freeze this register
- ex_valid  out  1  EX instruction valid
- ex_pc, ex_imm, ex_op_a, ex_op_b  out  DATA_WIDTH  registered PC, immediate, rs data, rt data
- ex_rs, ex_rt, ex_dest  out  REG_ADDR_WIDTH  sources and selected destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered control
- ex_alu_op  out  4  registered ALU code
- id_stall  out  1  combinational; freeze PC and IF/ID
- bubble_count  out  32  saturating count of inserted bubbles

## Operation
- Per-edge action, in priority order: reset, flush, ex_hold, load-use bubble, normal load.
- **Normal load** happens when id_stall is 0 and there is no flush. All ex_ outputs take their id_ counterparts.
  - ex_valid takes id_valid.
  - ex_dest is id_rd when id_reg_dst is 1, otherwise id_rt.
- **Operand select** for ex_op_a (same rule for ex_op_b with id_rt/ReadData2):
  - 0 when id_rs == 0.
  - Otherwise wb_write_data when wb_reg_write, wb_write_register == id_rs and id_rs != 0.
  - Otherwise ReadData1.
- **Load-use hazard** is asserted when all of these hold: id_valid, ex_valid, ex_mem_read, ex_dest != 0, and ex_dest equals id_rs or id_rt.
- **Bubble insertion:**
  - ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are cleared.
  - All other ex_ fields are zeroed.
  - id_stall = 1.
  - bubble_count increments, saturating at 0xFFFF_FFFF.
- **ex_hold** (no flush): every ex_ register keeps its value and id_stall = 1. No hazard bubble is inserted while held. The hazard is re-evaluated once hold drops.
- **flush:** same clearing as a bubble, but bubble_count is unchanged. id_stall = 0, because upstream discards ID itself. flush overrides ex_hold and hazard.
- id_stall = (ex_hold | load_use) & ~flush.

## Timing
- Latency: one cycle, ID inputs to ex_ outputs.
- Load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so the following cycle loads normally.
- The bypass is same-cycle. A WB write on edge N is visible in ex_op_a/b captured on edge N.
- Reset, asynchronous on falling reset:
  - All ex_ outputs and bubble_count go to 0, so id_stall = ex_hold.
  - Release is synchronous to clk.
- Reset asserted mid-stall drops the pending instruction; upstream re-fetches.
- A write-back to register 0 is never bypassed.
- Simultaneous hazard and flush: the flush wins and no count is taken.

## Structure
- Shared package musa_pkg:
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
  - ALU op encodings (4-bit).
  - Packed ID/EX control struct {reg_write, mem_read, mem_write, alu_src, alu_op}.
- Sub-module load_use_detect: combinational. Inputs ex_valid, ex_mem_read, ex_dest, id_valid, id_rs, id_rt; output load_use. The top level instantiates it and owns all state.

## Test plan
- **Reset mid-operation.** Load normal traffic, then pulse reset low for 3 ns mid-cycle. Every ex_ output and bubble_count must be 0 immediately; id_stall must follow ex_hold.
- **Normal flow.** id_rs=3, ReadData1=0x1234, id_rt=4, ReadData2=0x5678, id_reg_dst=1, id_rd=7. Next edge: ex_op_a=0x1234, ex_op_b=0x5678, ex_dest=7, ex_valid=1.
- **Load-use.** EX holds lw with ex_dest=5; ID has add with rs=5.
  - id_stall=1 for one cycle, a bubble enters EX and bubble_count becomes 1.
  - The add enters EX on the following edge.
- **WB bypass and register 0.**
  - wb_reg_write=1, wb_write_register=3, wb_write_data=0xDEAD with id_rs=3: ex_op_a=0xDEAD.
  - Same WB to register 0 with id_rs=0: ex_op_a=0.
- **Hold then flush.**
  - ex_hold=1 for 4 cycles: ex_ outputs are frozen and id_stall=1 throughout.
  - Assert flush together with ex_hold and a pending hazard: ex_valid=0, id_stall=0, bubble_count unchanged.
- **Saturation.** Preload bubble_count to 0xFFFF_FFFE via the hierarchy, then cause two hazards: the count ends at 0xFFFF_FFFF.
